player_health: RTL and testbench
================================

# player_health

Per-player health tracker that sits directly upstream of the on-screen blood display. It applies collision damage and pickup healing at frame boundaries and enforces an invulnerability window after each hit. It also provides passive regeneration and a sticky death state. It converts the current health value to tens/units digits with a small sequential subtract-by-ten converter, and the display stage indexes its digit sprites with those digits.

## Interface
Parameters:
- MAX_BLOOD, 99: full health and reset value; legal range 1..99 (two display digits).
- INVULN_FRAMES, 60: frames of invulnerability after a damaging hit.
- REGEN_FRAMES, 120: frames between +1 regeneration steps.
- BLINK_FRAMES, 4: half-period, in frames, of the Blink output during invulnerability.

Ports:
- Clk  in  1  system clock (sole clock domain).
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vertical-sync level from the VGA controller, sampled on Clk.
- Hit  in  1  level; collision with an enemy this frame.
- Hit_Damage  in  7  damage applied on an accepted hit.
- Heal  in  1  single-cycle pulse from a pickup, any cycle.
- Heal_Amount  in  7  amount associated with Heal.
- Player_Blood  out  10  current health, 0..MAX_BLOOD.
- Ten_Digit  out  4  tens digit of Player_Blood.
- Unit_Digit  out  4  units digit of Player_Blood.
- Digits_Valid  out  1  high when the digits match Player_Blood.
- Is_Dead  out  1  high in DEAD.
- Invincible  out  1  high in INVULN.
- Blink  out  1  sprite-flash enable for the player renderer.

## Operation
- Frame tick: register frame_clk once. Tick = 1 on the Clk cycle where the registered value is 0 and the current value is 1. All health updates occur only on tick cycles.
- Heal pending latch:
  - A Heal pulse sets the latch and captures Heal_Amount, saturating the sum at 127 if the latch is already set.
  - The latch clears on the next tick.
  - A Heal on the same cycle as a tick is applied on the following tick, not this one.
- States: ALIVE, INVULN, DEAD.
- ALIVE on tick, evaluated in this order:
  - 1) If Hit and Hit_Damage != 0: b = max(Player_Blood − Hit_Damage, 0).
  - 2) If b == 0: go to DEAD, discard the pending heal.
  - 3) Otherwise, with the heal applied: b = min(b + pending, MAX_BLOOD).
  - 4) If a hit was accepted: go to INVULN, load inv_cnt = INVULN_FRAMES−1, clear regen_cnt.
  - 5) If no hit: regen_cnt increments. When it reaches REGEN_FRAMES−1, it clears and adds +1, saturating at MAX_BLOOD after the heal.
- INVULN on tick:
  - Hit is ignored.
  - Heal is applied with saturation.
  - Regeneration is frozen.
  - inv_cnt decrements; on the tick where it is 0, go to ALIVE.
  - Blink toggles every BLINK_FRAMES ticks, starting at 1 on INVULN entry.
- DEAD: sticky until Reset; Hit, Heal and regeneration are ignored. Player_Blood = 0.
- Blink = 0 outside INVULN.
- Digit converter states: IDLE, CONV.
  - Whenever Player_Blood's next value differs from its current value, the converter loads rem = new value and tens = 0, enters CONV, and drives Digits_Valid = 0.
  - Each CONV cycle: if rem >= 10, then rem −= 10 and tens += 1. Otherwise Ten_Digit = tens, Unit_Digit = rem, Digits_Valid = 1, go to IDLE.
  - A new change during CONV restarts the conversion from the new value.
  - Ten_Digit and Unit_Digit hold their previous values while converting.

## Timing
- Reset values:
  - Player_Blood = MAX_BLOOD.
  - Ten_Digit / Unit_Digit = MAX_BLOOD/10 and MAX_BLOOD%10.
  - Digits_Valid = 1, state ALIVE, Is_Dead = 0, Invincible = 0, Blink = 0.
  - Heal latch, inv_cnt and regen_cnt cleared; converter IDLE; registered frame_clk = 0. The first rising edge after Reset therefore produces a tick if frame_clk is high.
- Player_Blood, Is_Dead and Invincible update on the Clk edge at the end of the tick cycle.
- Digit latency: the digits are valid T+1 cycles after Player_Blood changes, where T = new value / 10 (worst case 10 cycles).
- INVULN lasts exactly INVULN_FRAMES ticks. A Hit on the tick that exits INVULN is ignored; a Hit on the next tick is accepted.
- Reset asserted mid-conversion or mid-INVULN returns all state to reset values on the next edge.

## Test plan
- Reset, then frame ticks with no input, MAX_BLOOD = 99 → Player_Blood stays 99; digits 9/9 with Digits_Valid = 1.
- Hit with Hit_Damage = 27 at blood 99 → Player_Blood = 72 after the tick; Digits_Valid low for 8 cycles, then 7/2. Invincible = 1 for 60 ticks; a hit on tick 30 is ignored; a hit on tick 61 drops blood to 45.
- Blood 5, Hit with Hit_Damage = 10 on the same tick as a pending Heal of 20 → Player_Blood = 0, Is_Dead = 1, heal discarded; later Heal pulses and ticks leave the value at 0.
- Blood 95, Heal_Amount = 20, then a tick with no hit → Player_Blood = 99 (saturated). Blood 50 with REGEN_FRAMES = 120 → 51 after 120 ticks, no change at tick 119.
- Two Heal pulses of 100 and 50 within one frame → latch saturates at 127; at blood 10 the result is 99.
- Reset asserted while in INVULN during a conversion → the next cycle shows Player_Blood = 99, digits 9/9, Invincible = 0, Blink = 0.

Source files
------------

// File: rtl/player_health.sv
// player_health: frame-synchronous health tracker with hit invulnerability, heal latch, regen, sticky death and BCD digits
// Ports: Clk/Reset (sync, active-high); frame_clk vsync level; Hit/Hit_Damage collision per frame;
//        Heal/Heal_Amount pickup pulse; Player_Blood current health; Ten_Digit/Unit_Digit/Digits_Valid
//        decimal digits of Player_Blood; Is_Dead, Invincible state flags; Blink sprite flash enable.
module player_health #(
   parameter int MAX_BLOOD     = 99,
   parameter int INVULN_FRAMES = 60,
   parameter int REGEN_FRAMES  = 120,
   parameter int BLINK_FRAMES  = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       Hit,
   input  logic [6:0] Hit_Damage,
   input  logic       Heal,
   input  logic [6:0] Heal_Amount,
   output logic [9:0] Player_Blood,
   output logic [3:0] Ten_Digit,
   output logic [3:0] Unit_Digit,
   output logic       Digits_Valid,
   output logic       Is_Dead,
   output logic       Invincible,
   output logic       Blink
);
   localparam int IW = $clog2(INVULN_FRAMES + 1);
   localparam int RW = $clog2(REGEN_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [9:0]    BMAX       = 10'(MAX_BLOOD);
   localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES - 1);
   localparam logic [RW-1:0] REGEN_LAST = RW'(REGEN_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} hstate_t;
   typedef enum logic {IDLE, CONV} cstate_t;
   hstate_t       r_state, w_state_nxt;
   cstate_t       r_cstate, w_cstate_nxt;
   logic          r_frame_q;
   logic [6:0]    r_heal, w_heal_nxt;
   logic [9:0]    r_blood, w_blood_nxt;
   logic [IW-1:0] r_inv, w_inv_nxt;
   logic [RW-1:0] r_regen, w_regen_nxt;
   logic [BW-1:0] r_bcnt, w_bcnt_nxt;
   logic          r_blink, w_blink_nxt;
   logic [9:0]    r_rem, w_rem_nxt;
   logic [3:0]    r_tens, w_tens_nxt, r_ten, w_ten_nxt, r_unit, w_unit_nxt;
   logic          r_dvalid, w_dvalid_nxt;
   logic          w_tick, w_hit;
   logic [7:0]    w_heal_sum;
   logic [9:0]    w_dmg, w_after, w_healed, w_regened;
   logic [10:0]   w_sum;
   assign w_tick     = frame_clk & ~r_frame_q;
   assign w_heal_sum = {1'b0, r_heal} + {1'b0, Heal_Amount};
   // A heal arriving on the tick cycle is held for the next tick, so it restarts the latch instead of summing
   assign w_heal_nxt = w_tick ? (Heal ? Heal_Amount : 7'd0)
                     : Heal   ? (w_heal_sum[7] ? 7'h7f : w_heal_sum[6:0]) : r_heal;
   // Hits only count while vulnerable; in INVULN w_after is just the current blood
   assign w_hit      = (r_state == ALIVE) & Hit & (|Hit_Damage);
   assign w_dmg      = {3'b0, Hit_Damage};
   assign w_after    = !w_hit ? r_blood : (r_blood > w_dmg ? r_blood - w_dmg : 10'd0);
   assign w_sum      = {1'b0, w_after} + {4'b0, r_heal};
   assign w_healed   = (w_sum > {1'b0, BMAX}) ? BMAX : w_sum[9:0];
   assign w_regened  = (w_healed == BMAX) ? BMAX : w_healed + 10'd1;
   always_comb begin
      w_state_nxt = r_state;
      w_blood_nxt = r_blood;
      w_inv_nxt   = r_inv;
      w_regen_nxt = r_regen;
      w_bcnt_nxt  = r_bcnt;
      w_blink_nxt = r_blink;
      if (w_tick && r_state == ALIVE) begin
         if (w_after == 10'd0) begin
            w_state_nxt = DEAD;
            w_blood_nxt = 10'd0;
         end else if (w_hit) begin
            w_state_nxt = INVULN;
            w_blood_nxt = w_healed;
            w_inv_nxt   = INV_LOAD;
            w_regen_nxt = '0;
            w_bcnt_nxt  = '0;
            w_blink_nxt = 1'b1;
         end else begin
            w_blood_nxt = (r_regen == REGEN_LAST) ? w_regened : w_healed;
            w_regen_nxt = (r_regen == REGEN_LAST) ? '0 : r_regen + RW'(1);
         end
      end else if (w_tick && r_state == INVULN) begin
         w_blood_nxt = w_healed;
         w_state_nxt = (r_inv == '0) ? ALIVE : INVULN;
         w_inv_nxt   = (r_inv == '0) ? r_inv : r_inv - IW'(1);
         w_bcnt_nxt  = (r_bcnt == BLINK_LAST) ? '0 : r_bcnt + BW'(1);
         w_blink_nxt = (r_inv == '0) ? 1'b0 : (r_bcnt == BLINK_LAST) ? ~r_blink : r_blink;
      end
   end
   // Subtract-by-ten converter; any pending health change restarts it from the new value
   always_comb begin
      w_cstate_nxt = r_cstate;
      w_rem_nxt    = r_rem;
      w_tens_nxt   = r_tens;
      w_ten_nxt    = r_ten;
      w_unit_nxt   = r_unit;
      w_dvalid_nxt = r_dvalid;
      if (w_blood_nxt != r_blood) begin
         w_cstate_nxt = CONV;
         w_rem_nxt    = w_blood_nxt;
         w_tens_nxt   = 4'd0;
         w_dvalid_nxt = 1'b0;
      end else if (r_cstate == CONV) begin
         w_rem_nxt    = (r_rem >= 10'd10) ? r_rem - 10'd10 : r_rem;
         w_tens_nxt   = (r_rem >= 10'd10) ? r_tens + 4'd1 : r_tens;
         w_ten_nxt    = (r_rem >= 10'd10) ? r_ten : r_tens;
         w_unit_nxt   = (r_rem >= 10'd10) ? r_unit : r_rem[3:0];
         w_dvalid_nxt = (r_rem < 10'd10);
         w_cstate_nxt = (r_rem >= 10'd10) ? CONV : IDLE;
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= ALIVE;
         r_cstate  <= IDLE;
         r_frame_q <= 1'b0;
         r_heal    <= '0;
         r_blood   <= BMAX;
         r_inv     <= '0;
         r_regen   <= '0;
         r_bcnt    <= '0;
         r_blink   <= 1'b0;
         r_rem     <= '0;
         r_tens    <= '0;
         r_ten     <= 4'(MAX_BLOOD / 10);
         r_unit    <= 4'(MAX_BLOOD % 10);
         r_dvalid  <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_cstate  <= w_cstate_nxt;
         r_frame_q <= frame_clk;
         r_heal    <= w_heal_nxt;
         r_blood   <= w_blood_nxt;
         r_inv     <= w_inv_nxt;
         r_regen   <= w_regen_nxt;
         r_bcnt    <= w_bcnt_nxt;
         r_blink   <= w_blink_nxt;
         r_rem     <= w_rem_nxt;
         r_tens    <= w_tens_nxt;
         r_ten     <= w_ten_nxt;
         r_unit    <= w_unit_nxt;
         r_dvalid  <= w_dvalid_nxt;
      end
   end
   assign Player_Blood = r_blood;
   assign Ten_Digit    = r_ten;
   assign Unit_Digit   = r_unit;
   assign Digits_Valid = r_dvalid;
   assign Is_Dead      = (r_state == DEAD);
   assign Invincible   = (r_state == INVULN);
   assign Blink        = r_blink;
endmodule

// File: tb/tb_player_health.sv
// tb_player_health: scoreboard bench for player_health with directed frame-tick scenarios
module tb_player_health;
   logic       Clk = 1'b0;
   logic       Reset, frame_clk, Hit, Heal;
   logic [6:0] Hit_Damage, Heal_Amount;
   logic [9:0] Player_Blood;
   logic [3:0] Ten_Digit, Unit_Digit;
   logic       Digits_Valid, Is_Dead, Invincible, Blink;
   player_health dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Hit(Hit), .Hit_Damage(Hit_Damage),
      .Heal(Heal), .Heal_Amount(Heal_Amount), .Player_Blood(Player_Blood), .Ten_Digit(Ten_Digit),
      .Unit_Digit(Unit_Digit), .Digits_Valid(Digits_Valid), .Is_Dead(Is_Dead),
      .Invincible(Invincible), .Blink(Blink)
   );
   always #5 Clk = ~Clk;
   typedef struct packed {
      logic [9:0] b;
      logic [3:0] t;
      logic [3:0] u;
      logic [4:0] lows;
   } exp_t;
   exp_t sb[$];
   int n_pass = 0;
   int n_tot  = 0;
   task automatic chk(input string nm, input int act, input int req);
      n_tot++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, req);
   endtask
   task automatic push(input int b, input int t, input int u, input int l);
      exp_t e;
      e.b = 10'(b); e.t = 4'(t); e.u = 4'(u); e.lows = 5'(l);
      sb.push_back(e);
   endtask
   // Monitor: each rising Digits_Valid is a completed conversion; compare against the oldest expectation
   initial begin
      logic prev_dv;
      int   lows;
      exp_t e;
      prev_dv = 1'b1;
      lows = 0;
      forever begin
         @(negedge Clk);
         if (!Digits_Valid) lows++;
         else if (!prev_dv) begin
            if (sb.size() == 0) chk("sb_unexpected_digits", 1, 0);
            else begin
               e = sb.pop_front();
               chk("sb_blood", int'(Player_Blood), int'(e.b));
               chk("sb_ten", int'(Ten_Digit), int'(e.t));
               chk("sb_unit", int'(Unit_Digit), int'(e.u));
               chk("sb_latency", lows, int'(e.lows));
            end
            lows = 0;
         end
         prev_dv = Digits_Valid;
      end
   end
   task automatic tick(input logic h, input logic [6:0] d, input logic hl, input logic [6:0] ha);
      @(negedge Clk);
      frame_clk = 1'b1; Hit = h; Hit_Damage = d; Heal = hl; Heal_Amount = ha;
      @(negedge Clk);
      frame_clk = 1'b0; Hit = 1'b0; Hit_Damage = 7'd0; Heal = 1'b0;
   endtask
   task automatic settle();
      repeat (14) @(negedge Clk);
   endtask
   task automatic ticks(input int n);
      repeat (n) begin
         tick(1'b0, 7'd0, 1'b0, 7'd0);
         settle();
      end
   endtask
   task automatic heal(input logic [6:0] a);
      @(negedge Clk);
      Heal = 1'b1; Heal_Amount = a;
      @(negedge Clk);
      Heal = 1'b0;
   endtask
   initial begin
      Reset = 1'b1; frame_clk = 1'b0; Hit = 1'b0; Hit_Damage = 7'd0; Heal = 1'b0; Heal_Amount = 7'd0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      chk("rst_blood", int'(Player_Blood), 99);
      chk("rst_ten", int'(Ten_Digit), 9);
      chk("rst_unit", int'(Unit_Digit), 9);
      chk("rst_valid", int'(Digits_Valid), 1);
      chk("rst_dead", int'(Is_Dead), 0);
      chk("rst_inv", int'(Invincible), 0);
      chk("rst_blink", int'(Blink), 0);
      ticks(3);
      chk("idle_blood", int'(Player_Blood), 99);
      chk("idle_valid", int'(Digits_Valid), 1);
      push(72, 7, 2, 8);
      tick(1'b1, 7'd27, 1'b0, 7'd0);
      chk("hit27_blood", int'(Player_Blood), 72);
      chk("hit27_inv", int'(Invincible), 1);
      chk("hit27_blink", int'(Blink), 1);
      settle();
      for (int k = 1; k <= 60; k++) begin
         tick(k == 30 || k == 60, 7'd27, 1'b0, 7'd0);
         if (k == 3) chk("blink_t3", int'(Blink), 1);
         if (k == 4) chk("blink_t4", int'(Blink), 0);
         if (k == 8) chk("blink_t8", int'(Blink), 1);
         if (k == 30) chk("inv_hit_ignored", int'(Player_Blood), 72);
         if (k == 59) chk("inv_t59", int'(Invincible), 1);
         if (k == 60) begin
            chk("inv_exit", int'(Invincible), 0);
            chk("exit_blink", int'(Blink), 0);
            chk("exit_hit_ignored", int'(Player_Blood), 72);
         end
         settle();
      end
      push(99, 9, 9, 1);
      tick(1'b1, 7'd27, 1'b0, 7'd0);
      chk("hit61_blood", int'(Player_Blood), 45);
      chk("hit61_inv", int'(Invincible), 1);
      chk("hit61_converting", int'(Digits_Valid), 0);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("midrst_blood", int'(Player_Blood), 99);
      chk("midrst_ten", int'(Ten_Digit), 9);
      chk("midrst_unit", int'(Unit_Digit), 9);
      chk("midrst_inv", int'(Invincible), 0);
      chk("midrst_blink", int'(Blink), 0);
      chk("midrst_valid", int'(Digits_Valid), 1);
      settle();
      push(5, 0, 5, 1);
      tick(1'b1, 7'd94, 1'b0, 7'd0);
      settle();
      ticks(60);
      chk("at5_inv", int'(Invincible), 0);
      chk("at5_blood", int'(Player_Blood), 5);
      heal(7'd20);
      push(0, 0, 0, 1);
      tick(1'b1, 7'd10, 1'b0, 7'd0);
      chk("death_blood", int'(Player_Blood), 0);
      chk("death_dead", int'(Is_Dead), 1);
      chk("death_inv", int'(Invincible), 0);
      settle();
      heal(7'd50);
      ticks(2);
      chk("dead_sticky_blood", int'(Player_Blood), 0);
      chk("dead_sticky", int'(Is_Dead), 1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("revive_dead", int'(Is_Dead), 0);
      chk("revive_blood", int'(Player_Blood), 99);
      push(95, 9, 5, 10);
      tick(1'b1, 7'd4, 1'b0, 7'd0);
      settle();
      ticks(60);
      heal(7'd20);
      push(99, 9, 9, 10);
      tick(1'b0, 7'd0, 1'b0, 7'd0);
      chk("heal_sat", int'(Player_Blood), 99);
      settle();
      push(50, 5, 0, 6);
      tick(1'b1, 7'd49, 1'b0, 7'd0);
      settle();
      ticks(60);
      ticks(119);
      chk("regen_t119", int'(Player_Blood), 50);
      push(51, 5, 1, 6);
      tick(1'b0, 7'd0, 1'b0, 7'd0);
      chk("regen_t120", int'(Player_Blood), 51);
      settle();
      push(10, 1, 0, 2);
      tick(1'b1, 7'd41, 1'b0, 7'd0);
      settle();
      ticks(60);
      tick(1'b0, 7'd0, 1'b1, 7'd3);
      chk("heal_same_tick", int'(Player_Blood), 10);
      settle();
      heal(7'd100);
      heal(7'd50);
      push(99, 9, 9, 10);
      tick(1'b0, 7'd0, 1'b0, 7'd0);
      chk("heal_latch_sat", int'(Player_Blood), 99);
      settle();
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
